// File: rtl/song_reader.sv
// song_reader: walks one 128-word song in the song ROM and hands each word to
// the arranger. Per word the sequence is FETCH -> WAIT_ROM -> PRESENT -> WAIT_DONE.
// The ROM has one cycle of read latency. load_new_note and song_done are
// registered pulses. load_new_note is high in the first WAIT_DONE cycle, three
// cycles after the FETCH cycle. song_done is high in the first END cycle.
// Optional feature: define SONG_LOOP_EN for continuous playback. With it, END
// restarts the same song from word 0 while play is high.
module song_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic [1:0]  song,
  input  logic        note_done,
  output logic [8:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] note_to_load,
  output logic        load_new_note,
  output logic        song_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_PRESENT   = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_END       = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_index;
  logic [1:0]  r_song;
  logic [15:0] r_note;
  logic        r_load;
  logic        r_done;
  logic        w_last_idx;
  logic        w_load_nxt;
  logic        w_done_nxt;
  logic        w_end_exit;

  // The last word of a song has no successor; consuming it ends the song.
  assign w_last_idx    = &r_index;

  // The address is a pure function of the latched song and the word index.
  // Both are cleared by reset, so the address is zero right after reset.
  assign rom_addr      = {r_song, r_index};
  assign note_to_load  = r_note;
  assign load_new_note = r_load;
  assign song_done     = r_done;

  // State register; reset wins over every input.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (play) w_next = S_FETCH;
      S_FETCH:     if (play) w_next = S_WAIT_ROM;
      // rom_data now holds the word addressed during FETCH.
      S_WAIT_ROM:  w_next = (rom_data == 16'h0000) ? S_END : S_PRESENT;
      S_PRESENT:   w_next = S_WAIT_DONE;
      // play is ignored here: the arranger pauses its own time advance.
      S_WAIT_DONE: if (note_done) w_next = w_last_idx ? S_END : S_FETCH;
`ifdef SONG_LOOP_EN
      S_END:       w_next = play ? S_FETCH : S_IDLE;
`else
      S_END:       if (!play) w_next = S_IDLE;
`endif
      default:     w_next = S_IDLE;
    endcase
  end

  // Output decode; the pulses are registered one cycle later.
  always_comb begin
    w_load_nxt = (r_state == S_PRESENT);
    w_done_nxt = (w_next == S_END) && (r_state != S_END);
    w_end_exit = (r_state == S_END) && (w_next != S_END);
  end

  // Word index: advance on consumption, hold at 127, restart when END is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index <= 7'd0;
    end else if (r_state == S_WAIT_DONE && note_done && !w_last_idx) begin
      r_index <= r_index + 7'd1;
    end else if (w_end_exit) begin
      r_index <= 7'd0;
    end
  end

  // Song select is captured only when playback starts from IDLE.
  always_ff @(posedge clk) begin
    if (reset)                        r_song <= 2'd0;
    else if (r_state == S_IDLE && play) r_song <= song;
  end

  // Capture the ROM word. It stays stable until the next fetch completes.
  always_ff @(posedge clk) begin
    if (reset)                      r_note <= 16'h0000;
    else if (r_state == S_WAIT_ROM) r_note <= rom_data;
  end

  // Registered handshake pulses; they can never overlap in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_load <= w_load_nxt;
      r_done <= w_done_nxt;
    end
  end

endmodule
